uart_frame_parser: RTL

Consumes the byte stream produced by the UART receiver (rx_data/rx_valid strobes) and decodes framed commands of the form HDR0 HDR1 CMD LEN PAYLOAD[LEN] CSUM. It streams payload bytes out with an index and reports a single end-of-frame result (ok or error code) per frame. An inter-byte timeout discards frames left incomplete by a dropped or stalled line. It sits between the UART receiver and the command/register logic.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_byte_timeout.sv | 35 +++
 rtl/uart_frame_parser.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART command frame parser
// and the transmit-side response builder.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR1W,
    CMD,
    LEN,
    PAYLOAD,
    CSUM
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CSUM    = 2'b01,
    ERR_LEN     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_e;

  localparam logic [7:0] DEF_HDR0        = 8'h55;
  localparam logic [7:0] DEF_HDR1        = 8'hAA;
  localparam int         DEF_MAX_LEN     = 16;
  localparam int         DEF_TIMEOUT_CYC = 5000;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter: counts enabled, non-cleared cycles and pulses
// expire_o for one cycle when the count reaches TIMEOUT_CYC-1.
module uart_byte_timeout #(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int             CW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q, count_d;

  // A clear on the terminal cycle suppresses the expire: the byte wins.
  always_comb begin
    expire_o = enable_i && !clear_i && (count_q == TERM);
    count_d  = '0;
    if (enable_i && !clear_i && !expire_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Decodes HDR0 HDR1 CMD LEN PAYLOAD[LEN] CSUM frames from the UART receiver,
// streaming indexed payload bytes and one registered result per frame.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] HDR0        = DEF_HDR0,
  parameter logic [7:0] HDR1        = DEF_HDR1,
  parameter int         MAX_LEN     = DEF_MAX_LEN,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pld_data,
  output logic [7:0] pld_idx,
  output logic       pld_valid,
  output logic [7:0] frame_cmd,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e    state_q, state_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] pld_data_q, pld_data_d;
  logic [7:0] pld_idx_q, pld_idx_d;
  logic       pld_valid_q, pld_valid_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic       done_q, done_d;
  logic       ok_q, ok_d;
  err_code_e  err_q, err_d;
  logic       expire;

  uart_byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear_i (rx_valid),
    .enable_i(state_q != IDLE),
    .expire_o(expire)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d     = state_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    pld_data_d  = pld_data_q;
    pld_idx_d   = pld_idx_q;
    pld_valid_d = 1'b0;
    cmd_d       = cmd_q;
    len_d       = len_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    err_d       = err_q;

    if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == HDR0) state_d = HDR1W;
        end
        HDR1W: begin
          if (rx_data == HDR1)      state_d = CMD;
          else if (rx_data != HDR0) state_d = IDLE;
        end
        CMD: begin
          cmd_d   = rx_data;
          sum_d   = rx_data;
          state_d = LEN;
        end
        LEN: begin
          len_d = rx_data;
          sum_d = sum_q + rx_data;
          if (rx_data > MAX_LEN_B) begin
            done_d  = 1'b1;
            ok_d    = 1'b0;
            err_d   = ERR_LEN;
            state_d = IDLE;
          end else if (rx_data == 8'd0) begin
            state_d = CSUM;
          end else begin
            idx_d   = 8'd0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          pld_valid_d = 1'b1;
          pld_data_d  = rx_data;
          pld_idx_d   = idx_q;
          sum_d       = sum_q + rx_data;
          idx_d       = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = CSUM;
        end
        CSUM: begin
          done_d  = 1'b1;
          ok_d    = (rx_data == sum_q);
          err_d   = (rx_data == sum_q) ? ERR_NONE : ERR_CSUM;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (expire) begin
      // A stalled second header byte is not yet a frame attempt.
      state_d = IDLE;
      if (state_q != HDR1W) begin
        done_d = 1'b1;
        ok_d   = 1'b0;
        err_d  = ERR_TIMEOUT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      pld_data_q  <= 8'd0;
      pld_idx_q   <= 8'd0;
      pld_valid_q <= 1'b0;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      pld_data_q  <= pld_data_d;
      pld_idx_q   <= pld_idx_d;
      pld_valid_q <= pld_valid_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  assign pld_data   = pld_data_q;
  assign pld_idx    = pld_idx_q;
  assign pld_valid  = pld_valid_q;
  assign frame_cmd  = cmd_q;
  assign frame_len  = len_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign err_code   = err_q;
  assign busy       = (state_q != IDLE);

endmodule
